// File: rtl/sd4_mac_pkg.sv
// sd4_mac_pkg: shared widths, tag type and sequencer states for the SD4 MAC scheduler.
package sd4_mac_pkg;
    localparam int MAC_LAT = 3;
    localparam int SUM_W = 20;
    localparam int IMG_W = 72;
    localparam int WGT_W = 36;
    localparam int EXP_W = 5;
    localparam int WIN_W = 16;
    localparam int CH_W = 8;

    typedef struct packed {
        logic [WIN_W-1:0] win;
        logic [CH_W-1:0]  ch;
        logic             last;
    } tag_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sd4_res_fifo.sv
// sd4_res_fifo: first-word fall-through synchronous FIFO with occupancy count.
module sd4_res_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 6,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_pop;

    assign valid = count != '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && valid;
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
        assert (!(push && full && !do_pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sd4_mac_scheduler.sv
// sd4_mac_scheduler: issues N x C operand words into the non-stallable MAC and
// collects tagged sums in a credit-protected result FIFO.
module sd4_mac_scheduler
    import sd4_mac_pkg::*;
#(
    parameter int RES_DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] cfg_num_win,
    input  logic [CH_W-1:0]  cfg_num_ch,
    output logic             busy,
    output logic             done,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [IMG_W-1:0] op_image,
    input  logic [WGT_W-1:0] op_weight,
    input  logic [EXP_W-1:0] op_exp_bias,
    output logic [IMG_W-1:0] mac_image,
    output logic [WGT_W-1:0] mac_weight,
    output logic [EXP_W-1:0] mac_exp_bias,
    input  logic [SUM_W-1:0] mac_signed_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic [WIN_W-1:0] res_win,
    output logic [CH_W-1:0]  res_ch,
    output logic             res_last
);
    localparam int CRW = $clog2(RES_DEPTH + 1);

    state_t             state;
    logic [WIN_W-1:0]   num_win, win;
    logic [CH_W-1:0]    num_ch, ch;
    logic [CRW-1:0]     credit, res_count;
    tag_t               pipe [MAC_LAT];
    logic [MAC_LAT-1:0] pipe_vld;
    logic               hs, pop, last;
    tag_t               res_tag;

    assign op_ready = state == RUN && credit < CRW'(RES_DEPTH);
    assign hs = op_valid && op_ready;
    assign pop = res_valid && res_ready;
    assign last = ch == num_ch - CH_W'(1);
    assign mac_image = hs ? op_image : '0;
    assign mac_weight = hs ? op_weight : '0;
    assign mac_exp_bias = hs ? op_exp_bias : '0;
    assign {res_win, res_ch, res_last} = res_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            num_win <= '0;
            num_ch <= '0;
            win <= '0;
            ch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    num_win <= cfg_num_win;
                    num_ch <= cfg_num_ch;
                    win <= '0;
                    ch <= '0;
                    busy <= 1'b1;
                    state <= (cfg_num_win == '0 || cfg_num_ch == '0) ? DONE : RUN;
                    done <= cfg_num_win == '0 || cfg_num_ch == '0;
                end
                RUN: if (hs) begin
                    ch <= last ? '0 : ch + CH_W'(1);
                    win <= last ? win + WIN_W'(1) : win;
                    if (last && win == num_win - WIN_W'(1))
                        state <= DRAIN;
                end
                DRAIN: if (pipe_vld == '0 && res_count == '0) begin
                    state <= DONE;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe tracks the MAC's fixed latency; credit counts in-flight ops plus queued results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            credit <= '0;
            for (int i = 0; i < MAC_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe_vld <= {pipe_vld[MAC_LAT-2:0], hs};
            pipe[0] <= {win, ch, last};
            for (int i = 1; i < MAC_LAT; i++)
                pipe[i] <= pipe[i-1];
            credit <= credit + CRW'(hs) - CRW'(pop);
        end
    end

    sd4_res_fifo #(
        .W($bits(tag_t) + SUM_W),
        .DEPTH(RES_DEPTH),
        .CW(CRW)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(pipe_vld[MAC_LAT-1]),
        .push_data({pipe[MAC_LAT-1], mac_signed_sum}),
        .pop(pop),
        .pop_data({res_tag, res_sum}),
        .valid(res_valid),
        .count(res_count)
    );
endmodule

// File: tb/tb_sd4_mac_scheduler.sv
// tb_sd4_mac_scheduler: randomized directed jobs against an index-based tag model
// and a behavioural 3-stage MAC model.
module tb_sd4_mac_scheduler;
    logic        clk = 0, rst = 0, start = 0, op_valid = 0, res_ready = 0;
    logic [15:0] cfg_num_win = 0;
    logic [7:0]  cfg_num_ch = 0;
    logic [71:0] op_image = 0;
    logic [35:0] op_weight = 0;
    logic [4:0]  op_exp_bias = 0;
    logic        busy, done, op_ready, res_valid, res_last;
    logic [71:0] mac_image;
    logic [35:0] mac_weight;
    logic [4:0]  mac_exp_bias;
    logic [19:0] mac_signed_sum, s1, s2, s3, res_sum;
    logic [15:0] res_win;
    logic [7:0]  res_ch;

    typedef struct {int win; int ch; int last; logic [19:0] sum;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;
    int n_cfg, c_cfg, issued, popped, dones, stalls, readys, first_hs, first_pop, last_pop, cyc, done_cyc;

    sd4_mac_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_win(cfg_num_win), .cfg_num_ch(cfg_num_ch),
        .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready), .op_image(op_image),
        .op_weight(op_weight), .op_exp_bias(op_exp_bias), .mac_image(mac_image),
        .mac_weight(mac_weight), .mac_exp_bias(mac_exp_bias), .mac_signed_sum(mac_signed_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_win(res_win),
        .res_ch(res_ch), .res_last(res_last)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mac_f(logic [71:0] im, logic [35:0] w, logic [4:0] e);
        int s;
        s = int'(e);
        for (int i = 0; i < 9; i++)
            s += int'(im[8*i +: 8]) * int'($signed(w[4*i +: 4]));
        return s[19:0];
    endfunction

    // Free-running MAC: three register stages from presentation to signed_sum.
    always @(posedge clk) begin
        s1 <= mac_f(mac_image, mac_weight, mac_exp_bias);
        s2 <= s1;
        s3 <= s2;
    end
    assign mac_signed_sum = s3;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic hs, pop;
        exp_t e;
        #1;
        hs = op_valid && op_ready;
        pop = res_valid && res_ready;
        chk("mac_out", {mac_image, mac_weight, mac_exp_bias},
            hs ? {op_image, op_weight, op_exp_bias} : 113'd0);
        if (op_ready) readys++;
        if (busy && issued < n_cfg * c_cfg && !op_ready) stalls++;
        if (hs) begin
            if (issued == 0) first_hs = cyc;
            e.win = issued / c_cfg;
            e.ch = issued % c_cfg;
            e.last = int'(e.ch == c_cfg - 1);
            e.sum = mac_f(op_image, op_weight, op_exp_bias);
            exp_q.push_back(e);
            issued++;
        end
        if (pop) begin
            if (popped == 0) first_pop = cyc;
            last_pop = cyc;
            popped++;
            if (exp_q.size() == 0) chk("extra_result", res_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("res_win", res_win, e.win);
                chk("res_ch", res_ch, e.ch);
                chk("res_last", res_last, e.last);
                chk("res_sum", res_sum, e.sum);
            end
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            chk("done_fifo_empty", exp_q.size(), 0);
            chk("done_all_issued", issued, n_cfg * c_cfg);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(int vpct, logic rr, logic zero);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        op_valid = $urandom_range(99) < vpct;
        op_image = zero ? 72'd0 : r[71:0];
        op_weight = 36'({$urandom(), $urandom()});
        op_exp_bias = zero ? 5'd0 : 5'($urandom());
        res_ready = rr;
    endtask

    task automatic begin_job(int n, int c);
        cfg_num_win = 16'(n);
        cfg_num_ch = 8'(c);
        n_cfg = n; c_cfg = c;
        issued = 0; popped = 0; dones = 0; stalls = 0; readys = 0;
        cyc = 0; first_hs = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
        start = 1; op_valid = 0; res_ready = 1;
        tick();
        start = 0;
    endtask

    task automatic run_job(int vpct, int rmode, logic zero);
        for (int k = 0; k < 600 && dones == 0; k++) begin
            if (rmode == 2 && k == 30) begin
                chk("stall_issued", issued, 6);
                chk("stall_op_ready", op_ready, 0);
                chk("stall_res_valid", res_valid, 1);
            end
            drive(vpct, rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(1)) : 1'(k >= 30), zero);
            tick();
        end
        chk("done_once", dones, 1);
        drive(0, 1'b1, 1'b0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("result_count", popped, n_cfg * c_cfg);
    endtask

    initial begin
        op_valid = 1;
        op_image = 72'hFF_FFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res", {res_sum, res_win, res_ch, res_last}, 0);
        chk("rst_mac", {mac_image, mac_weight, mac_exp_bias}, 0);
        op_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;

        begin_job(1, 1);
        run_job(100, 0, 1'b1);
        chk("t1_latency", first_pop - first_hs, 4);

        begin_job(2, 3);
        run_job(100, 0, 1'b0);
        chk("t2_no_stall", stalls, 0);
        chk("t2_back_to_back", last_pop - first_pop + 1, 6);

        begin_job(4, 4);
        run_job(100, 2, 1'b0);

        begin_job(5, 3);
        run_job(50, 1, 1'b0);
        begin_job(3, 7);
        run_job(70, 1, 1'b0);

        begin_job(0, 3);
        run_job(100, 0, 1'b0);
        chk("n0_no_ready", readys, 0);
        chk("n0_done_fast", done_cyc >= 1 && done_cyc <= 2, 1);
        begin_job(3, 0);
        run_job(100, 0, 1'b0);
        chk("c0_no_ready", readys, 0);

        begin_job(4, 4);
        repeat (3) begin
            drive(100, 1'b1, 1'b0);
            tick();
        end
        chk("mid_issued", issued, 3);
        op_valid = 1;
        #2 rst = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_op_ready", op_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res", {res_sum, res_win, res_ch, res_last}, 0);
        chk("mid_rst_mac", {mac_image, mac_weight, mac_exp_bias}, 0);
        @(negedge clk);
        rst = 1;
        op_valid = 0;
        exp_q.delete();
        begin_job(1, 2);
        run_job(100, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd4_mac_scheduler.md
Name: sd4_mac_scheduler

Overview:
Job sequencer for the SD4 3x3 MAC pipeline (input_reg -> ppg/ppg_align -> alignment/align_add -> adder_tree). It takes a job (N windows x C channel passes), pulls operand words from an upstream buffer with valid/ready, and issues at most one operand word per cycle into the free-running, non-stallable MAC. It carries a tag alongside each operation through a latency-matched shift register and captures each signed_sum with its tag into a result FIFO. Credit-based issue keeps the FIFO from overflowing under downstream backpressure.

Parameters:
MAC_LAT, 3, register stages in the MAC from operand presentation to a valid signed_sum
RES_DEPTH, 6, result FIFO entries; a value of at least MAC_LAT+2 sustains 1 op/cycle
WIN_W, 16, window counter width
CH_W, 8, channel counter width
SUM_W, 20, MAC signed_sum width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  job start pulse, sampled in IDLE only
cfg_num_win  in  WIN_W  windows per job (N)
cfg_num_ch  in  CH_W  channel passes per window (C)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
op_valid  in  1  operand word available
op_ready  out  1  operand accepted when op_valid && op_ready
op_image  in  72  nine 8-bit image elements
op_weight  in  36  nine 4-bit SD4 weights
op_exp_bias  in  5  exponent bias
mac_image  out  72  to MAC input_reg
mac_weight  out  36  to MAC input_reg
mac_exp_bias  out  5  to MAC
mac_signed_sum  in  SUM_W  adder_tree output
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer ready
res_sum  out  SUM_W  captured signed_sum
res_win  out  WIN_W  window index
res_ch  out  CH_W  channel index
res_last  out  1  last channel of the window (ch == C-1)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all counters, credits, tag valids and FIFO pointers cleared; busy=0, done=0, op_ready=0, res_valid=0, res_* =0, mac_* =0. In-flight MAC results are discarded because their tag valids are cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch cfg. If N==0 or C==0, go to DONE; otherwise go to RUN. start in any other state is ignored.
- RUN: op_ready = (credit < RES_DEPTH), where credit is a registered count of in-flight ops plus FIFO entries. On handshake:
  - mac_* = op_* combinationally in the same cycle; otherwise mac_* = 0.
  - Push tag {win, ch, last} into stage 0.
  - ch increments; at C-1 it wraps to 0 and win increments.
  - The handshake with win==N-1 and ch==C-1 moves to DRAIN.
- Credit: +1 per issue, -1 per FIFO pop, both in the same cycle = no change. A FIFO push does not change credit.
- Tag pipe: MAC_LAT stages, shifting every cycle. When the tag in stage MAC_LAT-1 is valid, {tag, mac_signed_sum} is pushed to the FIFO on the next edge.
- Timing: an op accepted on edge E appears at res_* (first-word fall-through) after edge E+MAC_LAT.
- FIFO: pop on res_valid && res_ready. Simultaneous push and pop is legal. Credits make overflow impossible; a push into a full FIFO is an assertion failure.
- DRAIN: op_ready=0. When the tag pipe is empty and the FIFO is empty, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 from the edge that leaves IDLE until the return to IDLE.
- Counters wrap only under the explicit N/C rules above; a job issues exactly N*C ops.

Decomposition:
- Package sd4_mac_pkg holds: MAC_LAT, SUM_W, operand widths (72/36/5), and the tag struct type {win, ch, last}.
- One sub-module, sd4_res_fifo: a parameterised FWFT synchronous FIFO with count output.

Test Plan:
- N=1, C=1, all-zero image, op_valid held high, res_ready=1. Handshake at edge 1 -> res_valid after edge 4 with res_sum=0, win=0, ch=0, last=1. done pulses exactly once, after the FIFO empties.
- N=2, C=3, continuous op_valid, res_ready=1 -> six results on consecutive cycles with tags (0,0,0),(0,1,0),(0,2,1),(1,0,0),(1,1,0),(1,2,1). res_sum matches the bench MAC model per word. op_ready never drops.
- N=4, C=4 with res_ready=0 -> exactly 6 ops accepted, then op_ready=0 with credit=6. Raising res_ready -> all 16 results arrive in order, none lost or duplicated.
- Random op_valid bubbles (50%) -> results stay in issue order, and mac_* =0 in cycles with no handshake.
- start with N=0 -> done pulses two cycles later, op_ready never asserts.
- Assert rst low mid-RUN with 3 ops in flight -> all outputs read 0 immediately. After release, a new job produces only its own results.
